ram_sdp: RTL and testbench
==========================

# ram_sdp

Parametrised simple-dual-port RAM for the CPU memory subsystem and the next generation of the single-port 4K×16 RAM. One write port and one independent read port share a single clock. Adds byte enables, selectable read latency with a read-valid strobe, read-during-write bypass, out-of-range detection, and a post-reset clear engine that zeroes the array before accepting traffic. Sits between the CPU load/store unit and instruction fetch, and serves as a generic scratch buffer elsewhere.

## Interface
- DATA_W, 16, word width; must be a multiple of 8
- ADDR_W, 12, address width
- DEPTH, 4096, number of words; DEPTH ≤ 2^ADDR_W
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- BYPASS, 1, 1 = read-during-write to the same address returns new data; 0 = returns old data
- CLEAR_ON_RESET, 1, 1 = zero every word after reset
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  synchronous reset, active-low
- busy  out  1  clear engine running; requests are ignored while high
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i]
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data; holds its last value when rd_valid=0
- rd_valid  out  1  one-cycle strobe per accepted read
- addr_err  out  1  one-cycle pulse on an out-of-range request

## Operation
- Clock: single clock `clk`. Reset: `rst_n`, synchronous, active-low. Both are fixed.
- Reset values: rd_data=0, rd_valid=0, addr_err=0, all pipeline stages invalid. busy=CLEAR_ON_RESET. Clear pointer=0.
- Array contents are not reset by rst_n. They are zeroed only by the clear engine.
- FSM states:
  - CLEAR: entered on reset when CLEAR_ON_RESET=1. Writes 0 to address ptr, then ptr+1, one word per cycle. After writing DEPTH-1, moves to IDLE and busy falls.
  - IDLE: normal operation. Entered on reset when CLEAR_ON_RESET=0.
- Reset asserted mid-clear restarts the clear from address 0.
- While busy=1: wr_en and rd_en are ignored, with no array write, no rd_valid, and no addr_err.
- Write (IDLE, wr_en=1, wr_addr<DEPTH): on the edge, the bytes with wr_be=1 are written and the other bytes are kept. wr_be=0 is a legal no-op write.
- Read (IDLE, rd_en=1, rd_addr<DEPTH): the word is returned RD_LAT cycles later with rd_valid=1.
- Same-address write and read in the same cycle:
  - BYPASS=1: the returned word is the merged value (enabled bytes from wr_data, other bytes old).
  - BYPASS=0: the returned word is the pre-write content.
  - Different addresses are fully independent.
- Out-of-range (addr ≥ DEPTH), possible only when DEPTH < 2^ADDR_W:
  - Write: dropped; addr_err pulses in the next cycle.
  - Read: still produces rd_valid after RD_LAT with rd_data=0, and addr_err is asserted aligned with that rd_valid.
  - If a write error and a read error land in the same cycle, addr_err is a single pulse.
- Back-to-back reads are accepted every cycle. Throughput is 1 read plus 1 write per cycle; there is no backpressure.

## Timing
- Read, RD_LAT=1: rd_en sampled at edge N, so rd_data/rd_valid are valid after edge N (visible during cycle N+1).
- Read, RD_LAT=2: one extra output register, so data is valid after edge N+1.
- Write: takes effect at edge N. A read issued at edge N+1 sees it for any BYPASS setting.
- Clear duration: reset released at edge R, so busy=1 for DEPTH cycles after R. The first accepted request is at edge R+DEPTH.
- rd_valid is never high for two cycles from a single request. The pipeline drains normally if busy is not asserted. A reset flushes in-flight reads with no rd_valid.

## Test plan
- Clear:
  - Stimulus: DEPTH=16, CLEAR_ON_RESET=1, 2-cycle reset, then read all 16 addresses as soon as busy falls.
  - Required: busy high for exactly 16 cycles after release, then 16 rd_valid pulses, all with rd_data=0x0000.
- Byte enables:
  - Stimulus: write 0xA5A5 to addr 0x000 with be=11, then write 0x5A5A to addr 0x000 with be=01, then read.
  - Required: 0xA55A. With RD_LAT=2, rd_valid appears exactly 2 edges after rd_en.
- Bypass:
  - Stimulus: addr 0x001 holds 0x1234; same-cycle write 0xFFFF (be=10) and read of 0x001.
  - Required: BYPASS=1 returns 0xFF34; BYPASS=0 returns 0x1234. A following read returns 0xFF34 in both modes.
- Streaming:
  - Stimulus: write 0xFFFF, 0x0001, 0x0002 to addr 0x002–0x004, then read 0x002–0x004 on consecutive cycles.
  - Required: three consecutive rd_valid cycles with 0xFFFF, 0x0001, 0x0002.
- Out-of-range:
  - Stimulus: DEPTH=3000, write to addr 0xBB8, then read from 0xBB8.
  - Required: addr_err pulses after the write; the read gives rd_valid with 0x0000 and addr_err in the same cycle; addr 0x000 is unchanged.
- Reset mid-operation:
  - Reset mid-clear (ptr=7): busy stays high and the clear restarts, lasting DEPTH cycles from release.
  - Reset with a read in flight: no rd_valid, and rd_data=0.
  - Requests issued while busy produce no effect and no rd_valid.

Source files
------------

// File: rtl/ram_sdp.sv
// ram_sdp: simple-dual-port RAM with one write port and one read port on a single clock.
//
// Features: per-byte write enables, read latency of 1 or 2 cycles with a
// read-valid strobe, same-address read-during-write bypass (selectable), out-of-range
// detection, and a clear engine that zeroes the whole array after reset before any
// request is accepted.
//
// Ports:
//   clk, rst_n       - clock (rising edge) and synchronous active-low reset
//   busy             - clear engine running; wr_en/rd_en are ignored while high
//   wr_en, wr_addr,
//   wr_be, wr_data   - write request; wr_be[i] enables wr_data[8i+7:8i]
//   rd_en, rd_addr   - read request
//   rd_data          - read data, holds its last value when rd_valid is low
//   rd_valid         - one-cycle strobe per accepted read, RD_LAT cycles after rd_en
//   addr_err         - one-cycle pulse on an out-of-range write or read
//   dbg_state        - current FSM state (0 = IDLE, 1 = CLEAR)
//
// Request semantics: wr_en and rd_en are one-shot requests with no ready signal.
// A request is taken on every rising edge where it is high and busy is low, and
// there is no backpressure. rd_valid is a pure strobe, high for exactly one cycle
// per taken read; addr_err is high for one cycle per edge that saw an
// out-of-range write, or aligned with the rd_valid of an out-of-range read.
//
// Legal parameters: DATA_W a multiple of 8, DEPTH <= 2**ADDR_W, RD_LAT of 1 or 2.

module ram_sdp #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 12,
    parameter int DEPTH          = 4096,
    parameter int RD_LAT         = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  addr_err,
    output logic                  dbg_state
);

    localparam int NB = DATA_W / 8;
    // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              clr_we;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_acc, rd_acc;
    logic              wr_in, rd_in;
    logic              wr_do, wr_err, rd_err;
    logic [DATA_W-1:0] rd_word;

    logic              s1_v, s1_err;
    logic [DATA_W-1:0] s1_d;

    // ---------------------------------------------------------------------
    // Clear engine FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy    = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                ptr_d  = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                end
            end
            S_IDLE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dbg_state = state_q;

    // ---------------------------------------------------------------------
    // Request qualification
    // ---------------------------------------------------------------------
    assign wr_acc = wr_en & ~busy;
    assign rd_acc = rd_en & ~busy;
    assign wr_in  = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_in  = ({1'b0, rd_addr} < DEPTH_X);
    assign wr_do  = wr_acc & wr_in;
    assign wr_err = wr_acc & ~wr_in;
    assign rd_err = rd_acc & ~rd_in;

    // ---------------------------------------------------------------------
    // Storage. Not reset; only the clear engine zeroes it. Writes are
    // suppressed while rst_n is low so a reset edge never disturbs contents.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we) begin
                mem[ptr_q] <= '0;
            end else if (wr_do) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_be[b]) begin
                        mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Word returned for a read taken this cycle. Out-of-range reads return 0.
    // With BYPASS set, a same-address write in the same cycle overlays its
    // enabled bytes so the reader sees the post-write value.
    always_comb begin
        rd_word = '0;
        if (rd_in) begin
            rd_word = mem[rd_addr];
            if ((BYPASS != 0) && wr_do && (wr_addr == rd_addr)) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_be[b]) begin
                        rd_word[8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read pipeline. Stage 1 is only observed when RD_LAT == 2; the write
    // error is always reported one cycle after its request, so with RD_LAT == 2
    // it can coincide with a read error from the previous cycle and the two
    // merge into a single pulse.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s1_err   <= 1'b0;
            s1_d     <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            addr_err <= 1'b0;
        end else begin
            s1_v   <= rd_acc;
            s1_err <= rd_err;
            if (rd_acc) begin
                s1_d <= rd_word;
            end
            if (RD_LAT == 1) begin
                rd_valid <= rd_acc;
                addr_err <= wr_err | rd_err;
                if (rd_acc) begin
                    rd_data <= rd_word;
                end
            end else begin
                rd_valid <= s1_v;
                addr_err <= wr_err | s1_err;
                if (s1_v) begin
                    rd_data <= s1_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_sdp.sv
// Testbench for ram_sdp. Two instances share clock, reset and request inputs:
//   u_a: DEPTH=16,   RD_LAT=1, BYPASS=1
//   u_b: DEPTH=3000, RD_LAT=2, BYPASS=0
// Both have ADDR_W=12, so each has an out-of-range address region.

module tb_ram_sdp;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [1:0]  wr_be;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [11:0] rd_addr;

    logic        busy_a, rd_valid_a, addr_err_a, dbg_a;
    logic [15:0] rd_data_a;
    logic        busy_b, rd_valid_b, addr_err_b, dbg_b;
    logic [15:0] rd_data_b;

    int checks = 0;
    int errors = 0;

    // {busy, rd_valid, addr_err, rd_data}
    wire [18:0] obs_a = {busy_a, rd_valid_a, addr_err_a, rd_data_a};
    wire [18:0] obs_b = {busy_b, rd_valid_b, addr_err_b, rd_data_b};

    ram_sdp #(
        .DATA_W(16), .ADDR_W(12), .DEPTH(16), .RD_LAT(1), .BYPASS(1), .CLEAR_ON_RESET(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .busy(busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .addr_err(addr_err_a),
        .dbg_state(dbg_a)
    );

    ram_sdp #(
        .DATA_W(16), .ADDR_W(12), .DEPTH(3000), .RD_LAT(2), .BYPASS(0), .CLEAR_ON_RESET(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .busy(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .addr_err(addr_err_b),
        .dbg_state(dbg_b)
    );

    // ---------------------------------------------------------------------
    // Clock and watchdog
    // ---------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------------
    // Reference model: per instance, a word array, a count of remaining
    // clear cycles, and the previous cycle's read result for the 2-cycle
    // latency instance. exp_vec holds the expected {busy,valid,err,data}
    // after each rising edge.
    // ---------------------------------------------------------------------
    logic [15:0] m_mem [2][4096];
    int          clr_left [2];
    logic        h_v [2];
    logic        h_e [2];
    logic [15:0] h_d [2];
    logic [15:0] out_d [2];
    logic [18:0] exp_vec [2];

    int          m_depth, m_lat;
    logic        m_byp, m_acc_r, m_acc_w, m_oor_r, m_oor_w, m_vo, m_eo;
    logic [15:0] m_word, m_do;

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = nw[7:0];
        if (be[1]) r[15:8] = nw[15:8];
        return r;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_depth = (i == 0) ? 16 : 3000;
            m_lat   = (i == 0) ? 1 : 2;
            m_byp   = (i == 0);
            if (!rst_n) begin
                clr_left[i] = m_depth;
                h_v[i]      = 1'b0;
                h_e[i]      = 1'b0;
                h_d[i]      = 16'h0;
                out_d[i]    = 16'h0;
                exp_vec[i]  = {1'b1, 1'b0, 1'b0, 16'h0};
            end else begin
                m_acc_w = 1'b0;
                m_acc_r = 1'b0;
                m_word  = 16'h0;
                if (clr_left[i] > 0) begin
                    m_mem[i][m_depth - clr_left[i]] = 16'h0;
                    clr_left[i] = clr_left[i] - 1;
                end else begin
                    m_acc_w = wr_en;
                    m_acc_r = rd_en;
                end
                m_oor_w = m_acc_w && (int'(wr_addr) >= m_depth);
                m_oor_r = m_acc_r && (int'(rd_addr) >= m_depth);
                if (m_acc_r && !m_oor_r) begin
                    m_word = m_mem[i][rd_addr];
                    if (m_byp && m_acc_w && !m_oor_w && (wr_addr == rd_addr))
                        m_word = merge(m_word, wr_data, wr_be);
                end
                if (m_acc_w && !m_oor_w)
                    m_mem[i][wr_addr] = merge(m_mem[i][wr_addr], wr_data, wr_be);
                if (m_lat == 1) begin
                    m_vo = m_acc_r; m_do = m_word; m_eo = m_oor_r;
                end else begin
                    m_vo = h_v[i]; m_do = h_d[i]; m_eo = h_e[i];
                end
                h_v[i] = m_acc_r;
                h_d[i] = m_word;
                h_e[i] = m_oor_r;
                if (m_vo) out_d[i] = m_do;
                exp_vec[i] = {clr_left[i] > 0, m_vo, m_eo | m_oor_w, out_d[i]};
            end
        end
    end

    // ---------------------------------------------------------------------
    // Driver: apply one cycle of requests, then wait to the next falling edge
    // ---------------------------------------------------------------------
    task automatic step(input logic we, input logic [11:0] wa, input logic [1:0] be,
                        input logic [15:0] wd, input logic re, input logic [11:0] ra);
        wr_en   = we;
        wr_addr = wa;
        wr_be   = be;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 12'h0, 2'b00, 16'h0, 1'b0, 12'h0);
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        idle();
        checks++;
        if (obs_a !== 19'h40000) begin
            errors++;
            $display("FAIL reset_a: got %h expected %h", obs_a, 19'h40000);
        end
        checks++;
        if (obs_b !== 19'h40000) begin
            errors++;
            $display("FAIL reset_b: got %h expected %h", obs_b, 19'h40000);
        end
    endtask

    task automatic test_clear();
        int na = 0, nb = 0, cnt_a = 0, cnt_b = 0, ra = 0, cyc = 0;
        rst_n = 1'b1;
        while (busy_b === 1'b1 && cyc < 4000) begin
            if (busy_a === 1'b1) na++;
            nb++;
            if (rd_valid_a === 1'b1) begin
                cnt_a++;
                checks++;
                if (rd_data_a !== 16'h0) begin
                    errors++;
                    $display("FAIL clear_data_a: addr %0d got %h expected 0000", cnt_a - 1, rd_data_a);
                end
            end
            if (rd_valid_b === 1'b1) cnt_b++;
            if (busy_a === 1'b0 && ra < 16) begin
                step(1'b0, 12'h0, 2'b00, 16'h0, 1'b1, 12'(ra));
                ra++;
            end else begin
                idle();
            end
            cyc++;
        end
        checks++;
        if (na != 16) begin
            errors++;
            $display("FAIL clear_busy_a: got %0d cycles expected 16", na);
        end
        checks++;
        if (nb != 3000) begin
            errors++;
            $display("FAIL clear_busy_b: got %0d cycles expected 3000", nb);
        end
        checks++;
        if (cnt_a != 16) begin
            errors++;
            $display("FAIL clear_reads_a: got %0d rd_valid expected 16", cnt_a);
        end
        checks++;
        if (cnt_b != 0) begin
            errors++;
            $display("FAIL busy_ignore_b: got %0d rd_valid expected 0", cnt_b);
        end
    endtask

    task automatic test_byte_en();
        step(1'b1, 12'h000, 2'b11, 16'hA5A5, 1'b0, 12'h0);
        step(1'b1, 12'h000, 2'b01, 16'h5A5A, 1'b0, 12'h0);
        step(1'b0, 12'h0, 2'b00, 16'h0, 1'b1, 12'h000);
        checks++;
        if ({rd_valid_a, rd_data_a} !== {1'b1, 16'hA55A}) begin
            errors++;
            $display("FAIL byte_en_a: got %b/%h expected 1/a55a", rd_valid_a, rd_data_a);
        end
        checks++;
        if (rd_valid_b !== 1'b0) begin
            errors++;
            $display("FAIL byte_en_b_early: got rd_valid %b expected 0", rd_valid_b);
        end
        idle();
        checks++;
        if ({rd_valid_b, rd_data_b} !== {1'b1, 16'hA55A}) begin
            errors++;
            $display("FAIL byte_en_b: got %b/%h expected 1/a55a", rd_valid_b, rd_data_b);
        end
        checks++;
        if ({rd_valid_a, rd_data_a} !== {1'b0, 16'hA55A}) begin
            errors++;
            $display("FAIL hold_a: got %b/%h expected 0/a55a", rd_valid_a, rd_data_a);
        end
        idle();
        checks++;
        if ({rd_valid_b, rd_data_b} !== {1'b0, 16'hA55A}) begin
            errors++;
            $display("FAIL hold_b: got %b/%h expected 0/a55a", rd_valid_b, rd_data_b);
        end
    endtask

    task automatic test_bypass();
        step(1'b1, 12'h001, 2'b11, 16'h1234, 1'b0, 12'h0);
        step(1'b1, 12'h001, 2'b10, 16'hFFFF, 1'b1, 12'h001);
        checks++;
        if ({rd_valid_a, rd_data_a} !== {1'b1, 16'hFF34}) begin
            errors++;
            $display("FAIL bypass_new_a: got %b/%h expected 1/ff34", rd_valid_a, rd_data_a);
        end
        step(1'b0, 12'h0, 2'b00, 16'h0, 1'b1, 12'h001);
        checks++;
        if ({rd_valid_a, rd_data_a} !== {1'b1, 16'hFF34}) begin
            errors++;
            $display("FAIL bypass_after_a: got %b/%h expected 1/ff34", rd_valid_a, rd_data_a);
        end
        checks++;
        if ({rd_valid_b, rd_data_b} !== {1'b1, 16'h1234}) begin
            errors++;
            $display("FAIL bypass_old_b: got %b/%h expected 1/1234", rd_valid_b, rd_data_b);
        end
        idle();
        checks++;
        if ({rd_valid_b, rd_data_b} !== {1'b1, 16'hFF34}) begin
            errors++;
            $display("FAIL bypass_after_b: got %b/%h expected 1/ff34", rd_valid_b, rd_data_b);
        end
        idle();
    endtask

    task automatic test_stream();
        logic [15:0] sd [3];
        sd[0] = 16'hFFFF;
        sd[1] = 16'h0001;
        sd[2] = 16'h0002;
        for (int k = 0; k < 3; k++)
            step(1'b1, 12'(2 + k), 2'b11, sd[k], 1'b0, 12'h0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 12'h0, 2'b00, 16'h0, k < 3, 12'(2 + k));
            checks++;
            if (k < 3) begin
                if ({rd_valid_a, rd_data_a} !== {1'b1, sd[k]}) begin
                    errors++;
                    $display("FAIL stream_a[%0d]: got %b/%h expected 1/%h", k, rd_valid_a, rd_data_a, sd[k]);
                end
            end else if (rd_valid_a !== 1'b0) begin
                errors++;
                $display("FAIL stream_a[%0d]: got rd_valid %b expected 0", k, rd_valid_a);
            end
            checks++;
            if (k >= 1 && k <= 3) begin
                if ({rd_valid_b, rd_data_b} !== {1'b1, sd[k-1]}) begin
                    errors++;
                    $display("FAIL stream_b[%0d]: got %b/%h expected 1/%h", k, rd_valid_b, rd_data_b, sd[k-1]);
                end
            end else if (rd_valid_b !== 1'b0) begin
                errors++;
                $display("FAIL stream_b[%0d]: got rd_valid %b expected 0", k, rd_valid_b);
            end
        end
    endtask

    task automatic test_oor();
        step(1'b1, 12'hBB8, 2'b11, 16'hDEAD, 1'b0, 12'h0);
        checks++;
        if ({rd_valid_a, addr_err_a, rd_valid_b, addr_err_b} !== 4'b0101) begin
            errors++;
            $display("FAIL oor_wr: got v/e a=%b%b b=%b%b expected a=01 b=01",
                     rd_valid_a, addr_err_a, rd_valid_b, addr_err_b);
        end
        step(1'b0, 12'h0, 2'b00, 16'h0, 1'b1, 12'hBB8);
        checks++;
        if ({rd_valid_a, addr_err_a, rd_data_a} !== {2'b11, 16'h0}) begin
            errors++;
            $display("FAIL oor_rd_a: got %b%b/%h expected 11/0000", rd_valid_a, addr_err_a, rd_data_a);
        end
        checks++;
        if ({rd_valid_b, addr_err_b} !== 2'b00) begin
            errors++;
            $display("FAIL oor_rd_b_early: got %b%b expected 00", rd_valid_b, addr_err_b);
        end
        idle();
        checks++;
        if ({rd_valid_b, addr_err_b, rd_data_b} !== {2'b11, 16'h0}) begin
            errors++;
            $display("FAIL oor_rd_b: got %b%b/%h expected 11/0000", rd_valid_b, addr_err_b, rd_data_b);
        end
        // Write and read errors together
        step(1'b1, 12'hBB8, 2'b11, 16'hFFFF, 1'b1, 12'hBB8);
        checks++;
        if ({rd_valid_a, addr_err_a, rd_valid_b, addr_err_b} !== 4'b1101) begin
            errors++;
            $display("FAIL oor_both: got a=%b%b b=%b%b expected a=11 b=01",
                     rd_valid_a, addr_err_a, rd_valid_b, addr_err_b);
        end
        idle();
        checks++;
        if ({rd_valid_a, addr_err_a, rd_valid_b, addr_err_b} !== 4'b0011) begin
            errors++;
            $display("FAIL oor_both_next: got a=%b%b b=%b%b expected a=00 b=11",
                     rd_valid_a, addr_err_a, rd_valid_b, addr_err_b);
        end
        idle();
        checks++;
        if ({addr_err_a, addr_err_b} !== 2'b00) begin
            errors++;
            $display("FAIL oor_pulse_end: got a=%b b=%b expected 0 0", addr_err_a, addr_err_b);
        end
        // In-range word 0 must be untouched
        step(1'b0, 12'h0, 2'b00, 16'h0, 1'b1, 12'h000);
        checks++;
        if ({rd_valid_a, rd_data_a} !== {1'b1, 16'hA55A}) begin
            errors++;
            $display("FAIL oor_addr0_a: got %b/%h expected 1/a55a", rd_valid_a, rd_data_a);
        end
        idle();
        checks++;
        if ({rd_valid_b, rd_data_b} !== {1'b1, 16'hA55A}) begin
            errors++;
            $display("FAIL oor_addr0_b: got %b/%h expected 1/a55a", rd_valid_b, rd_data_b);
        end
        idle();
    endtask

    task automatic test_random();
        logic        we, re;
        logic [11:0] wa, ra;
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(2990, 3010)) : 12'($urandom_range(0, 19));
            ra = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(2990, 3010)) : 12'($urandom_range(0, 19));
            if ($urandom_range(0, 3) == 0) ra = wa;
            step(we, wa, 2'($urandom_range(0, 3)), 16'($urandom), re, ra);
            checks++;
            if (obs_a !== exp_vec[0]) begin
                errors++;
                $display("FAIL random_a[%0d]: got %h expected %h", n, obs_a, exp_vec[0]);
            end
            checks++;
            if (obs_b !== exp_vec[1]) begin
                errors++;
                $display("FAIL random_b[%0d]: got %h expected %h", n, obs_b, exp_vec[1]);
            end
        end
        idle();
        idle();
    endtask

    task automatic test_reset_mid();
        int na = 0, cyc = 0;
        logic [11:0] a;
        // Read in flight when reset arrives
        step(1'b0, 12'h0, 2'b00, 16'h0, 1'b1, 12'h000);
        rst_n = 1'b0;
        step(1'b0, 12'h0, 2'b00, 16'h0, 1'b1, 12'h000);
        checks++;
        if (obs_a !== 19'h40000) begin
            errors++;
            $display("FAIL flush_a: got %h expected %h", obs_a, 19'h40000);
        end
        checks++;
        if (obs_b !== 19'h40000) begin
            errors++;
            $display("FAIL flush_b: got %h expected %h", obs_b, 19'h40000);
        end
        idle();
        checks++;
        if (obs_b !== 19'h40000) begin
            errors++;
            $display("FAIL flush_b_late: got %h expected %h", obs_b, 19'h40000);
        end
        // Reset again once the clear pointer has reached 7
        rst_n = 1'b1;
        repeat (7) idle();
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        while (busy_a === 1'b1 && na < 100) begin
            na++;
            checks++;
            if ({rd_valid_a, addr_err_a} !== 2'b00) begin
                errors++;
                $display("FAIL busy_req_a[%0d]: got v/e %b%b expected 00", na, rd_valid_a, addr_err_a);
            end
            a = (na % 2 == 1) ? 12'h005 : 12'h020;
            step(1'b1, a, 2'b11, 16'hBEEF, 1'b1, a);
        end
        checks++;
        if ({rd_valid_a, addr_err_a} !== 2'b00) begin
            errors++;
            $display("FAIL busy_req_a_last: got v/e %b%b expected 00", rd_valid_a, addr_err_a);
        end
        checks++;
        if (na != 16) begin
            errors++;
            $display("FAIL restart_busy_a: got %0d cycles expected 16", na);
        end
        step(1'b0, 12'h0, 2'b00, 16'h0, 1'b1, 12'h005);
        checks++;
        if ({rd_valid_a, rd_data_a} !== {1'b1, 16'h0}) begin
            errors++;
            $display("FAIL busy_write_dropped_a: got %b/%h expected 1/0000", rd_valid_a, rd_data_a);
        end
        checks++;
        if ({busy_b, rd_valid_b} !== 2'b10) begin
            errors++;
            $display("FAIL busy_b_ignore: got busy/v %b%b expected 10", busy_b, rd_valid_b);
        end
        while (busy_b === 1'b1 && cyc < 4000) begin
            idle();
            cyc++;
        end
        checks++;
        if (busy_b !== 1'b0) begin
            errors++;
            $display("FAIL restart_busy_b: got busy %b after %0d cycles expected 0", busy_b, cyc);
        end
        step(1'b0, 12'h0, 2'b00, 16'h0, 1'b1, 12'h001);
        idle();
        checks++;
        if ({rd_valid_b, rd_data_b} !== {1'b1, 16'h0}) begin
            errors++;
            $display("FAIL restart_cleared_b: got %b/%h expected 1/0000", rd_valid_b, rd_data_b);
        end
    endtask

    // ---------------------------------------------------------------------
    // Sequence and report
    // ---------------------------------------------------------------------
    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 12'h0;
        wr_be   = 2'b00;
        wr_data = 16'h0;
        rd_en   = 1'b0;
        rd_addr = 12'h0;
        test_reset();
        test_clear();
        test_byte_en();
        test_bypass();
        test_stream();
        test_oor();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
